microsequencer: RTL and testbench

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/useq_pkg.sv | 70 +++++++
 rtl/ucode_rom.sv | 89 ++++++++
 rtl/microsequencer.sv | 100 ++++++++++
 tb/tb_microsequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// useq_pkg -- shared definitions for the microsequencer and its microcode ROM.
//
// Contents:
//   nextsel_t    : how the next micro-address is chosen after a microword
//   ctrl_t       : 16-bit control bundle, MSB first:
//                  irwrite, adrsrc, alusrca[1:0], alusrcb[1:0], resultsrc[1:0],
//                  nextpc, regw, memw, branch, aluop, memacc, rsvd[1:0]
//   microword_t  : one ROM entry (next-select, jump target, control bundle)
//   ADDR_*       : fixed microword addresses
//   SRCA_*/SRCB_*/RES_* : ALU operand and result multiplexer encodings
package useq_pkg;

    typedef enum logic [2:0] {
        NS_SEQ   = 3'd0,
        NS_JUMP  = 3'd1,
        NS_DISP1 = 3'd2,
        NS_DISP2 = 3'd3,
        NS_FETCH = 3'd4
    } nextsel_t;

    // Jump targets are stored wider than the default micro-PC so the ROM
    // format does not change if the micro-PC is widened.
    localparam int NADDR_W = 8;

    localparam int ADDR_FETCH  = 0;
    localparam int ADDR_DECODE = 1;
    localparam int ADDR_MEMADR = 2;
    localparam int ADDR_MEMRD  = 3;
    localparam int ADDR_MEMWB  = 4;
    localparam int ADDR_MEMWR  = 5;
    localparam int ADDR_EXECR  = 6;
    localparam int ADDR_EXECI  = 7;
    localparam int ADDR_ALUWB  = 8;
    localparam int ADDR_BRANCH = 9;
    localparam int ADDR_TRAP   = 31;

    localparam logic [1:0] SRCA_OLDPC = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       memacc;
        logic [1:0] rsvd;
    } ctrl_t;

    typedef struct packed {
        nextsel_t             nsel;
        logic [NADDR_W-1:0]   naddr;
        ctrl_t                ctrl;
    } microword_t;

endpackage

// File: rtl/ucode_rom.sv
// ucode_rom -- purely combinational microcode store.
//
// Ports:
//   addr : input  [UPC_W-1:0]  micro-address to look up
//   word : output microword_t  next-select, jump target and control bundle
//
// Any address without a populated microword jumps to TRAP with every
// control bit cleared, so a stray micro-PC can never write state.
module ucode_rom
    import useq_pkg::*;
#(
    parameter int UPC_W = 5
) (
    input  logic [UPC_W-1:0] addr,
    output microword_t       word
);

    // Start from the "unpopulated" word, then fill in the fields each
    // populated address needs.
    always_comb begin
        word = '{nsel: NS_JUMP, naddr: NADDR_W'(ADDR_TRAP), ctrl: '0};
        case (int'(addr))
            ADDR_FETCH: begin
                word.nsel           = NS_SEQ;
                word.ctrl.irwrite   = 1'b1;
                word.ctrl.alusrca   = SRCA_PC;
                word.ctrl.alusrcb   = SRCB_FOUR;
                word.ctrl.resultsrc = RES_ALU;
                word.ctrl.nextpc    = 1'b1;
                word.ctrl.memacc    = 1'b1;
            end
            ADDR_DECODE: begin
                word.nsel           = NS_DISP1;
                word.ctrl.alusrca   = SRCA_OLDPC;
                word.ctrl.alusrcb   = SRCB_IMM;
            end
            ADDR_MEMADR: begin
                word.nsel           = NS_DISP2;
                word.ctrl.alusrca   = SRCA_REG;
                word.ctrl.alusrcb   = SRCB_IMM;
            end
            ADDR_MEMRD: begin
                word.nsel           = NS_SEQ;
                word.ctrl.adrsrc    = 1'b1;
                word.ctrl.resultsrc = RES_ALUOUT;
                word.ctrl.memacc    = 1'b1;
            end
            ADDR_MEMWB: begin
                word.nsel           = NS_FETCH;
                word.ctrl.resultsrc = RES_DATA;
                word.ctrl.regw      = 1'b1;
            end
            ADDR_MEMWR: begin
                word.nsel           = NS_FETCH;
                word.ctrl.adrsrc    = 1'b1;
                word.ctrl.resultsrc = RES_ALUOUT;
                word.ctrl.memw      = 1'b1;
                word.ctrl.memacc    = 1'b1;
            end
            ADDR_EXECR: begin
                word.naddr          = NADDR_W'(ADDR_ALUWB);
                word.ctrl.alusrca   = SRCA_REG;
                word.ctrl.alusrcb   = SRCB_REG;
                word.ctrl.aluop     = 1'b1;
            end
            ADDR_EXECI: begin
                word.naddr          = NADDR_W'(ADDR_ALUWB);
                word.ctrl.alusrca   = SRCA_REG;
                word.ctrl.alusrcb   = SRCB_IMM;
                word.ctrl.aluop     = 1'b1;
            end
            ADDR_ALUWB: begin
                word.nsel           = NS_FETCH;
                word.ctrl.resultsrc = RES_ALUOUT;
                word.ctrl.regw      = 1'b1;
            end
            ADDR_BRANCH: begin
                word.nsel           = NS_FETCH;
                word.ctrl.alusrca   = SRCA_REG;
                word.ctrl.alusrcb   = SRCB_REG;
                word.ctrl.resultsrc = RES_ALUOUT;
                word.ctrl.aluop     = 1'b1;
                word.ctrl.branch    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// microsequencer -- microcoded multicycle control unit.
//
// Ports:
//   clk      : input         rising-edge clock
//   reset    : input         asynchronous, active-low reset
//   Op       : input  [1:0]  instruction class
//   Funct    : input  [5:0]  instruction function bits
//   MemReady : input         memory access complete (wait-state builds only)
//   uPC      : output [UPC_W-1:0] current micro-address
//   CtrlWord : output [15:0] control bundle for the current microword
//   Retire   : output        one-cycle pulse as an instruction completes
//   Illegal  : output        high while parked in TRAP
//
// Build option: define MEM_WAIT_EN to stall on memory-access microwords
// until MemReady is high; otherwise MemReady is ignored.
module microsequencer
    import useq_pkg::*;
#(
    parameter int UPC_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic [UPC_W-1:0] uPC,
    output logic [15:0]      CtrlWord,
    output logic             Retire,
    output logic             Illegal
);

    microword_t       word;
    ctrl_t            ctrl;
    logic [UPC_W-1:0] upc_next;
    logic             stall;
    logic             bits_unused;

    ucode_rom #(.UPC_W(UPC_W)) u_rom (
        .addr (uPC),
        .word (word)
    );

`ifdef MEM_WAIT_EN
    // A memory microword cannot complete until the memory answers.
    assign stall       = word.ctrl.memacc & ~MemReady;
    assign bits_unused = &{1'b0, Funct[4:1], word.naddr};
`else
    assign stall       = 1'b0;
    assign bits_unused = &{1'b0, Funct[4:1], word.naddr, MemReady};
`endif

    // Micro-PC register; Retire is registered so that it lines up with the
    // cycle in which FETCH is actually showing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uPC    <= '0;
            Retire <= 1'b0;
        end else begin
            uPC    <= upc_next;
            Retire <= (upc_next == '0) && (uPC != '0);
        end
    end

    // Next micro-address from the next-select field and the dispatch tables.
    always_comb begin
        upc_next = UPC_W'(ADDR_TRAP);
        unique case (word.nsel)
            NS_SEQ:   upc_next = uPC + UPC_W'(1);
            NS_JUMP:  upc_next = UPC_W'(word.naddr);
            NS_DISP1: begin
                case (Op)
                    2'b00:   upc_next = Funct[5] ? UPC_W'(ADDR_EXECI) : UPC_W'(ADDR_EXECR);
                    2'b01:   upc_next = UPC_W'(ADDR_MEMADR);
                    2'b10:   upc_next = UPC_W'(ADDR_BRANCH);
                    default: upc_next = UPC_W'(ADDR_TRAP);
                endcase
            end
            NS_DISP2: upc_next = Funct[0] ? UPC_W'(ADDR_MEMRD) : UPC_W'(ADDR_MEMWR);
            NS_FETCH: upc_next = UPC_W'(ADDR_FETCH);
            default:  upc_next = UPC_W'(ADDR_TRAP);
        endcase
        if (stall) begin
            upc_next = uPC;
        end
    end

    // Control outputs: a stalled microword must not commit any write.
    always_comb begin
        ctrl = word.ctrl;
        if (stall) begin
            ctrl.irwrite = 1'b0;
            ctrl.regw    = 1'b0;
            ctrl.memw    = 1'b0;
            ctrl.nextpc  = 1'b0;
        end
        CtrlWord = ctrl;
        Illegal  = (uPC == UPC_W'(ADDR_TRAP));
    end

endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer -- directed, table-driven bench for microsequencer.
module tb_microsequencer;

    localparam logic [15:0] FETCH_WORD = 16'h9A84;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [4:0] upc;
        logic       retire;
        logic       illegal;
        logic       memw;
        logic       regw;
        logic       branch;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic        MemReady;
    logic [4:0]  uPC;
    logic [15:0] CtrlWord;
    logic        Retire;
    logic        Illegal;

    int checks;
    int failures;
    vec_t vecs[$];

    microsequencer #(.UPC_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Funct    (Funct),
        .MemReady (MemReady),
        .uPC      (uPC),
        .CtrlWord (CtrlWord),
        .Retire   (Retire),
        .Illegal  (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct, input logic memready);
        Op       = op;
        Funct    = funct;
        MemReady = memready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic [1:0] op, input logic [5:0] funct, input logic [4:0] upc,
                          input logic retire, input logic memw, input logic regw, input logic branch);
        vec_t v;
        v.op = op; v.funct = funct; v.upc = upc; v.retire = retire;
        v.illegal = (upc == 5'd31);
        v.memw = memw; v.regw = regw; v.branch = branch;
        vecs.push_back(v);
    endtask

    // Assert reset asynchronously, check the reset state, then release it
    // on a falling edge so the next observation is the first FETCH cycle.
    task automatic doReset();
        reset = 1'b0;
        #1;
        checkOutput("reset_upc", 32'(uPC), 32'd0);
        checkOutput("reset_ctrl", 32'(CtrlWord), 32'(FETCH_WORD));
        checkOutput("reset_retire", 32'(Retire), 32'd0);
        checkOutput("reset_illegal", 32'(Illegal), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_upc", 32'(uPC), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(2'b00, 6'b000000, 1'b1);

        // op, funct, upc, retire, memw, regw, branch
        addVec(2'b00, 6'b000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b00, 6'b000000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b00, 6'b000000, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b00, 6'b000000, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0);
        addVec(2'b01, 6'b000001, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        addVec(2'b01, 6'b000001, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b01, 6'b000001, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b01, 6'b000001, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b01, 6'b000001, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0);
        addVec(2'b01, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        addVec(2'b01, 6'b000000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b01, 6'b000000, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b01, 6'b000000, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0);
        addVec(2'b00, 6'b100000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        addVec(2'b00, 6'b100000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b00, 6'b100000, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b00, 6'b100000, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0);
        addVec(2'b10, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        addVec(2'b10, 6'b000000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        addVec(2'b10, 6'b000000, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1);
        addVec(2'b11, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        addVec(2'b11, 6'b000000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0);

        // Main instruction mix straight out of reset.
        #2;
        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].funct, 1'b1);
            #1;
            checkOutput($sformatf("v%0d_upc", i), 32'(uPC), 32'(vecs[i].upc));
            checkOutput($sformatf("v%0d_retire", i), 32'(Retire), 32'(vecs[i].retire));
            checkOutput($sformatf("v%0d_illegal", i), 32'(Illegal), 32'(vecs[i].illegal));
            checkOutput($sformatf("v%0d_memw", i), 32'(CtrlWord[5]), 32'(vecs[i].memw));
            checkOutput($sformatf("v%0d_regw", i), 32'(CtrlWord[6]), 32'(vecs[i].regw));
            checkOutput($sformatf("v%0d_branch", i), 32'(CtrlWord[4]), 32'(vecs[i].branch));
            if (vecs[i].upc == 5'd0) begin
                checkOutput($sformatf("v%0d_fetchword", i), 32'(CtrlWord), 32'(FETCH_WORD));
            end
            @(posedge clk);
        end
        #1;

        // TRAP is permanent whatever the instruction inputs do.
        for (int c = 0; c < 20; c++) begin
            applyStimulus(2'($urandom_range(3, 0)), 6'($urandom_range(63, 0)), 1'b1);
            #1;
            checkOutput("trap_upc", 32'(uPC), 32'd31);
            checkOutput("trap_illegal", 32'(Illegal), 32'd1);
            checkOutput("trap_memw", 32'(CtrlWord[5]), 32'd0);
            checkOutput("trap_regw", 32'(CtrlWord[6]), 32'd0);
            checkOutput("trap_retire", 32'(Retire), 32'd0);
            tick();
        end

        // Reset while in MEMRD abandons the load; no Retire afterwards.
        applyStimulus(2'b01, 6'b000001, 1'b1);
        doReset();
        tick();
        tick();
        tick();
        checkOutput("midrst_pre_upc", 32'(uPC), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_async_upc", 32'(uPC), 32'd0);
        checkOutput("midrst_async_retire", 32'(Retire), 32'd0);
        checkOutput("midrst_async_ctrl", 32'(CtrlWord), 32'(FETCH_WORD));
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(2'b00, 6'b000000, 1'b1);
        #1;
        checkOutput("midrst_first_upc", 32'(uPC), 32'd0);
        checkOutput("midrst_first_retire", 32'(Retire), 32'd0);
        tick();
        checkOutput("midrst_decode_upc", 32'(uPC), 32'd1);
        checkOutput("midrst_decode_retire", 32'(Retire), 32'd0);
        tick();
        checkOutput("midrst_exec_upc", 32'(uPC), 32'd6);

`ifdef MEM_WAIT_EN
        // FETCH waits three cycles for memory, then proceeds.
        doReset();
        applyStimulus(2'b00, 6'b000000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("wait_upc", 32'(uPC), 32'd0);
            checkOutput("wait_irwrite", 32'(CtrlWord[15]), 32'd0);
            checkOutput("wait_nextpc", 32'(CtrlWord[7]), 32'd0);
            checkOutput("wait_retire", 32'(Retire), 32'd0);
            @(posedge clk);
        end
        #1;
        MemReady = 1'b1;
        #1;
        checkOutput("wait_release_upc", 32'(uPC), 32'd0);
        checkOutput("wait_release_irwrite", 32'(CtrlWord[15]), 32'd1);
        tick();
        checkOutput("wait_done_upc", 32'(uPC), 32'd1);
`else
        // MemReady has no effect without wait states.
        doReset();
        applyStimulus(2'b00, 6'b000000, 1'b0);
        #1;
        checkOutput("nowait_irwrite", 32'(CtrlWord[15]), 32'd1);
        tick();
        checkOutput("nowait_upc", 32'(uPC), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
